// File: rtl/tp_const_bank.sv
// Double-buffered constant bank for the TP arithmetic: host writes go to a shadow
// copy, and a commit handshake swaps shadow into the active copy atomically.
module tp_const_bank #(
  parameter int NSETS  = 3,
  parameter int NCONST = 6,
  parameter int WIDTH  = 18
) (
  input  logic                          io_clk,
  input  logic                          io_reset_n,
  input  logic                          io_sel,
  input  logic                          io_sync,
  input  logic [15:0]                   io_addr,
  input  logic                          io_rd_en,
  input  logic                          io_wr_en,
  input  logic [31:0]                   io_wr_data,
  output logic [31:0]                   io_rd_data,
  output logic                          io_rd_ack,
  input  logic                          commit_ok,
  output logic                          commit_done,
  output logic                          commit_pending,
  output logic [NSETS*NCONST*WIDTH-1:0] const_out
);

  localparam int NTOT = NSETS * NCONST;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                  state_q;
  logic                    dirty_q;
  logic [15:0]             commit_count_q;
  logic signed [WIDTH-1:0] shadow_q [NTOT];
  logic signed [WIDTH-1:0] active_q [NTOT];

  int          sel_s_p0, sel_k_p0, sel_idx_p0;
  logic        cst_hit_p0, ctl_hit_p0;
  logic        rd_stb_p0, wr_stb_p0, shadow_wr_p0, ctl_wr_p0;
  logic        force_p0, abort_p0, req_p0, copy_p0;
  logic [31:0] rd_val_p0;
  logic        unused_wr_bits;

  function automatic logic [31:0] sext32(input logic signed [WIDTH-1:0] v);
    return 32'(v);
  endfunction

  // stage p0: address decode and control-write actions, all from the current io_* inputs
  always_comb begin
    sel_s_p0   = int'(io_addr[7:3]);
    sel_k_p0   = int'(io_addr[2:0]);
    sel_idx_p0 = sel_s_p0 * NCONST + sel_k_p0;
    cst_hit_p0 = io_sel && io_addr[15] && !io_addr[14] && (io_addr[12:8] == 5'd0)
                 && (sel_s_p0 < NSETS) && (sel_k_p0 < NCONST);
    ctl_hit_p0 = io_sel && io_addr[15] && io_addr[14] && (io_addr[12:8] == 5'd0)
                 && (io_addr[7:0] == 8'd0);
  end

  assign rd_stb_p0    = io_sync & io_sel & io_rd_en;
  assign wr_stb_p0    = io_sync & io_sel & io_wr_en;
  assign shadow_wr_p0 = wr_stb_p0 & cst_hit_p0 & ~io_addr[13];
  assign ctl_wr_p0    = wr_stb_p0 & ctl_hit_p0;
  assign force_p0     = ctl_wr_p0 & io_wr_data[2];
  assign abort_p0     = ctl_wr_p0 & io_wr_data[1];
  assign req_p0       = ctl_wr_p0 & io_wr_data[0] & ~io_wr_data[1];
  // An abort on the same edge as commit_ok cancels the pending swap; force always copies.
  assign copy_p0      = force_p0 | ((state_q == PENDING) & commit_ok & ~abort_p0);
  assign unused_wr_bits = ^io_wr_data;

  always_comb begin
    rd_val_p0 = '0;
    if (cst_hit_p0) begin
      for (int i = 0; i < NTOT; i++) begin
        if (i == sel_idx_p0)
          rd_val_p0 = io_addr[13] ? sext32(active_q[i]) : sext32(shadow_q[i]);
      end
    end else if (ctl_hit_p0) begin
      rd_val_p0 = {commit_count_q, 14'd0, dirty_q, state_q == PENDING};
    end
  end

  // stage p1: registered state, read response and active copy
  always_ff @(posedge io_clk) begin
    if (!io_reset_n) begin
      state_q        <= IDLE;
      dirty_q        <= 1'b0;
      commit_count_q <= '0;
      io_rd_data     <= '0;
      io_rd_ack      <= 1'b0;
      commit_done    <= 1'b0;
      for (int i = 0; i < NTOT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      io_rd_ack   <= rd_stb_p0;
      commit_done <= copy_p0;
      if (rd_stb_p0)
        io_rd_data <= rd_val_p0;

      if (copy_p0) begin
        for (int i = 0; i < NTOT; i++)
          active_q[i] <= shadow_q[i];
        commit_count_q <= commit_count_q + 16'd1;
      end

      if (shadow_wr_p0) begin
        for (int i = 0; i < NTOT; i++) begin
          if (i == sel_idx_p0)
            shadow_q[i] <= signed'(io_wr_data[WIDTH-1:0]);
        end
      end

      // A write landing on the copy edge is not in the new active set, so dirty stays set.
      if (shadow_wr_p0)
        dirty_q <= 1'b1;
      else if (copy_p0)
        dirty_q <= 1'b0;

      if (copy_p0 || abort_p0)
        state_q <= IDLE;
      else if (req_p0)
        state_q <= PENDING;
    end
  end

  assign commit_pending = (state_q == PENDING);

  always_comb begin
    const_out = '0;
    for (int i = 0; i < NTOT; i++)
      const_out[i*WIDTH +: WIDTH] = active_q[i];
  end

endmodule

// File: tb/tb_tp_const_bank.sv
// Bench for tp_const_bank: directed test-plan scenarios plus random bus traffic
// compared against a set/constant-indexed behavioural model.
module tb_tp_const_bank;

  localparam int NS = 3;
  localparam int NC = 6;
  localparam int W  = 18;

  logic io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  logic              io_reset_n, io_sel, io_sync, io_rd_en, io_wr_en, commit_ok;
  logic [15:0]       io_addr;
  logic [31:0]       io_wr_data, io_rd_data;
  logic              io_rd_ack, commit_done, commit_pending;
  logic [NS*NC*W-1:0] const_out;

  logic              b_reset_n, b_sel, b_sync, b_rd_en, b_wr_en, b_commit_ok;
  logic [15:0]       b_addr;
  logic [31:0]       b_wr_data, b_rd_data;
  logic              b_rd_ack, b_commit_done, b_commit_pending;
  logic [4*8*32-1:0] b_const_out;

  tp_const_bank dut (
    .io_clk(io_clk), .io_reset_n(io_reset_n), .io_sel(io_sel), .io_sync(io_sync),
    .io_addr(io_addr), .io_rd_en(io_rd_en), .io_wr_en(io_wr_en), .io_wr_data(io_wr_data),
    .io_rd_data(io_rd_data), .io_rd_ack(io_rd_ack), .commit_ok(commit_ok),
    .commit_done(commit_done), .commit_pending(commit_pending), .const_out(const_out)
  );

  tp_const_bank #(.NSETS(4), .NCONST(8), .WIDTH(32)) dut_wide (
    .io_clk(io_clk), .io_reset_n(b_reset_n), .io_sel(b_sel), .io_sync(b_sync),
    .io_addr(b_addr), .io_rd_en(b_rd_en), .io_wr_en(b_wr_en), .io_wr_data(b_wr_data),
    .io_rd_data(b_rd_data), .io_rd_ack(b_rd_ack), .commit_ok(b_commit_ok),
    .commit_done(b_commit_done), .commit_pending(b_commit_pending), .const_out(b_const_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: constants held as sign-extended 32-bit values per [set][const]
  logic [31:0] m_sh [NS][NC];
  logic [31:0] m_ac [NS][NC];
  bit          m_pend, m_dirty, m_ack, m_done;
  logic [15:0] m_cnt;
  logic [31:0] m_rd;

  function automatic logic [31:0] sx(input logic [31:0] d);
    logic [31:0] msk;
    msk = (32'd1 << W) - 32'd1;
    return d[W-1] ? (d | ~msk) : (d & msk);
  endfunction

  function automatic logic [NS*NC*W-1:0] exp_co();
    logic [NS*NC*W-1:0] v;
    v = '0;
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < NC; k++)
        v[(s*NC+k)*W +: W] = m_ac[s][k][W-1:0];
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < NC; k++) begin
        m_sh[s][k] = '0;
        m_ac[s][k] = '0;
      end
    m_pend = 0; m_dirty = 0; m_ack = 0; m_done = 0; m_cnt = '0; m_rd = '0;
  endtask

  task automatic check_outputs(input string pfx);
    chk({pfx, "_rd_ack"}, io_rd_ack, m_ack);
    chk({pfx, "_rd_data"}, io_rd_data, m_rd);
    chk({pfx, "_done"}, commit_done, m_done);
    chk({pfx, "_pending"}, commit_pending, m_pend);
    chk({pfx, "_const_out"}, const_out, exp_co());
  endtask

  task automatic do_reset();
    @(negedge io_clk);
    io_reset_n = 1'b0; io_sync = 1'b0; io_rd_en = 1'b0; io_wr_en = 1'b0;
    @(posedge io_clk); #1;
    model_reset();
    check_outputs("reset");
    @(negedge io_clk);
    io_reset_n = 1'b1;
  endtask

  task automatic step(input logic sel, input logic sync, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [31:0] d, input logic cok);
    int s, k;
    bit hit_c, hit_ctl, rs, ws, ctl, frc, abt, req, cp;
    @(negedge io_clk);
    io_sel = sel; io_sync = sync; io_rd_en = rd; io_wr_en = wr;
    io_addr = a; io_wr_data = d; commit_ok = cok;
    s = int'(a[7:3]);
    k = int'(a[2:0]);
    hit_c   = sel && a[15] && !a[14] && a[12:8] == 5'd0 && s < NS && k < NC;
    hit_ctl = sel && a[15] && a[14] && a[12:8] == 5'd0 && a[7:0] == 8'd0;
    rs = sync && sel && rd;
    ws = sync && sel && wr;
    m_ack = rs;
    if (rs) begin
      if (hit_c)        m_rd = a[13] ? m_ac[s][k] : m_sh[s][k];
      else if (hit_ctl) m_rd = {m_cnt, 14'd0, m_dirty, m_pend};
      else              m_rd = '0;
    end
    ctl = ws && hit_ctl;
    frc = ctl && d[2];
    abt = ctl && d[1];
    req = ctl && d[0] && !d[1];
    cp  = frc || (m_pend && cok && !abt);
    m_done = cp;
    if (cp) begin
      m_ac = m_sh;
      m_cnt = m_cnt + 16'd1;
      m_dirty = 0;
      m_pend = 0;
    end else if (abt) m_pend = 0;
    else if (req) m_pend = 1;
    if (ws && hit_c && !a[13]) begin
      m_sh[s][k] = sx(d);
      m_dirty = 1;
    end
    @(posedge io_clk); #1;
    check_outputs("step");
  endtask

  task automatic idle(input logic cok);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, cok);
  endtask

  initial begin
    io_reset_n = 0; io_sel = 0; io_sync = 0; io_rd_en = 0; io_wr_en = 0;
    io_addr = '0; io_wr_data = '0; commit_ok = 0;
    b_reset_n = 0; b_sel = 0; b_sync = 0; b_rd_en = 0; b_wr_en = 0;
    b_addr = '0; b_wr_data = '0; b_commit_ok = 0;
    model_reset();

    // Wide instance: (3,7) = 0x80000000 through shadow, force commit, active read-back
    @(posedge io_clk); #1;
    chk("wide_reset_const", b_const_out[1023:896], 128'h0);
    @(negedge io_clk);
    b_reset_n = 1; b_sel = 1; b_sync = 1; b_wr_en = 1; b_addr = 16'h801F; b_wr_data = 32'h8000_0000;
    @(negedge io_clk);
    b_addr = 16'hC000; b_wr_data = 32'h4;
    @(posedge io_clk); #1;
    chk("wide_done", b_commit_done, 1'b1);
    chk("wide_const", b_const_out[(3*8+7)*32 +: 32], 32'h8000_0000);
    @(negedge io_clk);
    b_wr_en = 0; b_rd_en = 1; b_addr = 16'hA01F;
    @(posedge io_clk); #1;
    chk("wide_rd_ack", b_rd_ack, 1'b1);
    chk("wide_rd_active", b_rd_data, 32'h8000_0000);
    @(negedge io_clk);
    b_sync = 0; b_rd_en = 0;

    do_reset();

    // Defaults: shadow write, sign-extended read-back, active still zero
    step(1, 1, 0, 1, 16'h800A, 32'h0003_FFFF, 0);
    step(1, 1, 1, 0, 16'h800A, 32'h0, 0);
    chk("dflt_ack", io_rd_ack, 1'b1);
    chk("dflt_shadow", io_rd_data, 32'hFFFF_FFFF);
    idle(0);
    chk("dflt_ack_drop", io_rd_ack, 1'b0);
    chk("dflt_hold", io_rd_data, 32'hFFFF_FFFF);
    step(1, 1, 1, 0, 16'hA00A, 32'h0, 0);
    chk("dflt_active", io_rd_data, 32'h0);

    // Commit handshake
    step(1, 1, 0, 1, 16'hC000, 32'h1, 0);
    repeat (10) idle(0);
    chk("cm_pending", commit_pending, 1'b1);
    chk("cm_not_yet", const_out, 128'h0);
    idle(1);
    chk("cm_done", commit_done, 1'b1);
    chk("cm_const12", const_out[(1*NC+2)*W +: W], 18'h3FFFF);
    idle(0);
    chk("cm_done_pulse", commit_done, 1'b0);
    step(1, 1, 1, 0, 16'hC000, 32'h0, 0);
    chk("cm_ctl", io_rd_data, 32'h0001_0000);

    // Abort, then force
    step(1, 1, 0, 1, 16'h8001, 32'h0000_0015, 0);
    step(1, 1, 0, 1, 16'hC000, 32'h1, 0);
    step(1, 1, 0, 1, 16'hC000, 32'h2, 0);
    chk("ab_pending", commit_pending, 1'b0);
    idle(1);
    chk("ab_no_done", commit_done, 1'b0);
    step(1, 1, 0, 1, 16'hC000, 32'h4, 0);
    chk("force_done", commit_done, 1'b1);
    chk("force_const01", const_out[(0*NC+1)*W +: W], 18'h00015);
    step(1, 1, 1, 0, 16'hC000, 32'h0, 0);
    chk("force_ctl", io_rd_data, 32'h0002_0000);

    // Shadow write on the copy edge
    step(1, 1, 0, 1, 16'h8000, 32'h0002_2222, 0);
    step(1, 1, 0, 1, 16'hC000, 32'h1, 0);
    step(1, 1, 0, 1, 16'h8000, 32'h0000_0001, 1);
    chk("col_active00", const_out[0 +: W], 18'h22222);
    step(1, 1, 1, 0, 16'hC000, 32'h0, 0);
    chk("col_ctl", io_rd_data, 32'h0003_0002);
    step(1, 1, 1, 0, 16'h8000, 32'h0, 0);
    chk("col_shadow", io_rd_data, 32'h0000_0001);

    // Out of range, and read+write in one operation
    step(1, 1, 0, 1, 16'h8030, 32'h0000_1234, 0);
    step(1, 1, 1, 0, 16'h8030, 32'h0, 0);
    chk("oor_s_ack", io_rd_ack, 1'b1);
    chk("oor_s_data", io_rd_data, 32'h0);
    step(1, 1, 0, 1, 16'h8007, 32'h0000_1234, 0);
    step(1, 1, 1, 0, 16'h8007, 32'h0, 0);
    chk("oor_k_data", io_rd_data, 32'h0);
    step(1, 1, 1, 1, 16'h8003, 32'h0001_1111, 0);
    chk("rw_pre_value", io_rd_data, 32'h0);

    // Reset while pending
    step(1, 1, 0, 1, 16'hC000, 32'h1, 0);
    chk("rst_pend_set", commit_pending, 1'b1);
    do_reset();
    idle(1);
    chk("rst_no_done", commit_done, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [15:0] a;
      logic [31:0] d;
      logic sel, sync, rd, wr, cok;
      d = $urandom;
      case ($urandom_range(0, 5))
        0, 1: a = 16'h8000 | 16'($urandom_range(0, 3) << 3) | 16'($urandom_range(0, 7));
        2:    a = 16'hA000 | 16'($urandom_range(0, 3) << 3) | 16'($urandom_range(0, 7));
        3: begin
          a = 16'hC000;
          d = 32'($urandom_range(0, 3)) | (($urandom_range(0, 7) == 0) ? 32'h4 : 32'h0);
        end
        4:    a = 16'($urandom);
        default: a = 16'h8000 | 16'($urandom_range(1, 31) << 8) | 16'($urandom_range(0, 7));
      endcase
      sel  = ($urandom_range(0, 9) != 0);
      sync = ($urandom_range(0, 3) != 0);
      rd   = $urandom_range(0, 1) == 1;
      wr   = $urandom_range(0, 1) == 1;
      cok  = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(sel, sync, rd, wr, a, d, cok);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tp_const_bank.md
# tp_const_bank

Parametrised, double-buffered constant register bank for the TP function. It holds NSETS × NCONST signed constants of WIDTH bits, programmable over the io_* bus. Host writes land in a shadow copy. A commit handshake transfers the shadow copy to the active copy atomically, so the processing pipeline never sees a half-updated set. It sits between the slave-address decoder and the TP arithmetic, and generalises the fixed 3-set × 6-constant × 18-bit bank.

## Interface
Parameters:
- NSETS, 3: number of constant sets; 1..32.
- NCONST, 6: constants per set; 1..8.
- WIDTH, 18: constant width, two's complement; 1..32.

Ports:
- io_clk, in, 1: single clock for all logic.
- io_reset_n, in, 1: reset; synchronous, active-low.
- io_sel, in, 1: module selected for an I/O operation.
- io_sync, in, 1: one-cycle strobe that starts the I/O operation.
- io_addr, in, 16: slave address.
- io_rd_en, in, 1: the operation is a read.
- io_wr_en, in, 1: the operation is a write.
- io_wr_data, in, 32: write data.
- io_rd_data, out, 32: read data, registered.
- io_rd_ack, out, 1: read data valid, registered.
- commit_ok, in, 1: from the TP pipeline; high when an active-copy swap is safe, e.g. between events.
- commit_done, out, 1: one-cycle pulse, coincident with new active values.
- commit_pending, out, 1: a commit has been requested and has not yet been applied.
- const_out, out, NSETS*NCONST*WIDTH: active constants. Constant (s,k) occupies bits [(s*NCONST+k)*WIDTH +: WIDTH].

## Operation
Address decode, valid only when io_sel=1 and io_addr[15]=1:
- Constant space: io_addr[14]=0. Set index s=io_addr[7:3], constant index k=io_addr[2:0].
  - io_addr[13]=0 selects the shadow copy, read/write.
  - io_addr[13]=1 selects the active copy, read-only.
- Control register: io_addr[14]=1 and io_addr[7:0]=0.
- Out of range: s≥NSETS, k≥NCONST, io_addr[12:8]≠0, or io_addr[15]=0. Writes are ignored. Reads return 0 and still ack.

Writes occur on cycles with io_sync&io_sel&io_wr_en:
- Shadow write: shadow[s][k] ← io_wr_data[WIDTH-1:0]. Sets dirty=1.
- Control write:
  - bit0 = commit request: set pending.
  - bit1 = abort: clear pending; abort wins over bit0.
  - bit2 = force: copy shadow→active this cycle, ignoring commit_ok.

Commit FSM, states IDLE and PENDING:
- IDLE→PENDING on commit request.
- PENDING→IDLE on the edge where commit_ok=1. On that edge: all active ← all shadow, dirty←0, commit_count+1.
- A commit request while already PENDING has no effect.
- Force copies from either state, returns to IDLE, and increments commit_count.

Reads occur on cycles with io_sync&io_sel&io_rd_en:
- Constant read: io_rd_data = selected value sign-extended from bit WIDTH-1 to 32 bits.
- Control read: bit0=pending, bit1=dirty, bits[31:16]=commit_count (16-bit, wraps 0xFFFF→0), other bits 0.

Boundary rules:
- Shadow write and copy on the same edge: the copy takes the pre-write shadow value; dirty stays 1.
- Read of the active copy on a copy edge returns the pre-copy value.
- io_sync with both io_rd_en and io_wr_en high: perform both; the read returns the pre-write value.

## Timing
- Reset (io_reset_n=0 at an edge): shadow=0, active=0, const_out=0, state IDLE, dirty=0, commit_count=0, io_rd_data=0, io_rd_ack=0, commit_done=0, commit_pending=0.
- Reset during PENDING: the request is discarded and no copy occurs.
- Read latency: io_rd_ack and io_rd_data are valid exactly 1 cycle after the io_sync edge. io_rd_ack is high for 1 cycle.
- io_rd_data holds its value until the next read.
- Writes take effect at the io_sync edge. A shadow value is readable by an io_sync on the next cycle.
- Commit request to copy: minimum 1 cycle. The request edge sets PENDING; the copy happens on the first later edge with commit_ok=1.
- const_out and commit_done change 1 cycle after that edge. commit_pending falls on the same cycle.
- commit_pending equals the registered PENDING state.

## Test plan
- Defaults. Write 0x3FFFF to 0x800A (set 1, constant 2), then read 0x800A → 0xFFFFFFFF, ack 1 cycle later. Read 0xA00A → 0. const_out is unchanged.
- Commit handshake: write 0xC000=0x1 with commit_ok=0 for 10 cycles → commit_pending=1 and const_out unchanged. Raise commit_ok → one commit_done pulse, constant (1,2)=0x3FFFF. Control read → 0x00010000.
- Abort: request, then write 0xC000=0x2 → pending=0. Pulse commit_ok → no copy. Force with 0x4 → copy happens and count increments.
- Collision: shadow write 0x00001 to (0,0) on the same edge as the commit copy → active (0,0) keeps the old value, dirty=1, shadow reads 0x00001.
- Out of range: write then read 0x8030 (s=6) and 0x8007 (k=7) → reads return 0 with ack. All constants are unchanged.
- Reset mid-PENDING: assert io_reset_n=0 for 1 cycle → all outputs 0. A later commit_ok pulse produces no commit_done.
- Parametrised: NSETS=4, NCONST=8, WIDTH=32: (3,7)=0x80000000 round-trips after commit.
